// File: rtl/trivium_encript.sv
// Trivium keystream generator: loads KEY/IV under reset, runs 1152 warm-up
// rounds, then shifts the next 512 keystream bits into OUT and freezes.
module trivium_encript (
  input  logic         clk,
  input  logic         reset,
  input  logic [79:0]  KEY,
  input  logic [79:0]  IV,
  output logic [511:0] OUT
);

  typedef enum logic [1:0] {
    INIT,
    GEN,
    DONE
  } phase_t;

  localparam logic [10:0] WARMUP_END = 11'd1152;
  localparam logic [10:0] GEN_END    = 11'd1664;

  // st[i-1] holds Trivium state bit s_i
  logic [287:0] st;
  logic [287:0] st_nxt;
  logic [10:0]  cnt;
  phase_t       phase;

  logic t1, t2, t3, z;
  logic t1n, t2n, t3n;

  always_comb begin
    phase = DONE;
    if (cnt < WARMUP_END) begin
      phase = INIT;
    end else if (cnt < GEN_END) begin
      phase = GEN;
    end
  end

  always_comb begin
    t1  = st[65]  ^ st[92];
    t2  = st[161] ^ st[176];
    t3  = st[242] ^ st[287];
    z   = t1 ^ t2 ^ t3;
    t1n = t1 ^ (st[90]  & st[91])  ^ st[170];
    t2n = t2 ^ (st[174] & st[175]) ^ st[263];
    t3n = t3 ^ (st[285] & st[286]) ^ st[68];
    st_nxt = {st[286:177], t2n, st[175:93], t1n, st[91:0], t3n};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= {3'b111, 108'b0, 4'b0, IV, 13'b0, KEY};
      cnt <= '0;
      OUT <= '0;
    end else begin
      unique case (phase)
        INIT: begin
          st  <= st_nxt;
          cnt <= cnt + 11'd1;
        end
        GEN: begin
          st  <= st_nxt;
          cnt <= cnt + 11'd1;
          OUT <= {OUT[510:0], z};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_encript.sv
// Self-checking bench for trivium_encript against a bit-array Trivium model.
module tb_trivium_encript;

  logic         clk;
  logic         reset;
  logic [79:0]  KEY;
  logic [79:0]  IV;
  logic [511:0] OUT;

  int errors;
  int checks;

  trivium_encript dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .IV    (IV),
    .OUT   (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [79:0] key;
    logic [79:0] iv;
  } vec_t;

  // Reference: s[1..288] as an array of bits, rounds applied literally.
  function automatic logic [511:0] model(input logic [79:0] k, input logic [79:0] v);
    bit s [1:288];
    bit a, b, c, zz;
    logic [511:0] ks;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    ks = '0;
    for (int r = 0; r < 1664; r++) begin
      a  = s[66] ^ s[93];
      b  = s[162] ^ s[177];
      c  = s[243] ^ s[288];
      zz = a ^ b ^ c;
      a  = a ^ (s[91] & s[92]) ^ s[171];
      b  = b ^ (s[175] & s[176]) ^ s[264];
      c  = c ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i >= 179; i--) s[i] = s[i-1];
      s[178] = b;
      for (int i = 177; i >= 95; i--) s[i] = s[i-1];
      s[94] = a;
      for (int i = 93; i >= 2; i--) s[i] = s[i-1];
      s[1] = c;
      if (r >= 1152) ks = {ks[510:0], zz};
    end
    return ks;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [79:0] k, input logic [79:0] v);
    reset = 1'b1;
    KEY   = k;
    IV    = v;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic run_vector(input vec_t t);
    logic [511:0] exp;
    logic [287:0] ld;
    int nonzero;
    exp = model(t.key, t.iv);
    load(t.key, t.iv);
    ld = {3'b111, 108'b0, 4'b0, t.iv, 13'b0, t.key};
    chk({t.name, " reset OUT"}, OUT, '0);
    chk({t.name, " reset state"}, {224'b0, dut.st}, {224'b0, ld});
    nonzero = 0;
    for (int e = 1; e <= 1152; e++) begin
      tick(1);
      if (OUT !== '0) nonzero++;
    end
    chk({t.name, " warm-up silent edges"}, 512'(nonzero), '0);
    tick(1);
    chk({t.name, " z1 at edge 1153"}, OUT, exp >> 511);
    tick(299);
    chk({t.name, " partial at edge 1452"}, OUT, exp >> 212);
    tick(212);
    chk({t.name, " full at edge 1664"}, OUT, exp);
    tick(336);
    chk({t.name, " frozen at edge 2000"}, OUT, exp);
  endtask

  vec_t vecs [4];
  logic [511:0] exp_a, exp_b;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    KEY    = '0;
    IV     = '0;

    vecs[0] = '{"iv_msb", 80'h0, 80'h80000000000000000000};
    vecs[1] = '{"all_zero", 80'h0, 80'h0};
    vecs[2] = '{"key_ones", 80'hFFFFFFFFFFFFFFFFFFFF, 80'h0123456789ABCDEF0123};
    vecs[3] = '{"mixed", 80'h0F62B5085BAE0154A7FA, 80'h288FF65DC42B92F960C7};

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    exp_a = model(80'h0, 80'h0);
    chk("all_zero keystream nonzero", 512'(exp_a != '0), 512'd1);

    // Reset in the middle of warm-up, switching to an all-ones key.
    exp_a = model(80'hFFFFFFFFFFFFFFFFFFFF, 80'h80000000000000000000);
    load(80'h0, 80'h80000000000000000000);
    tick(800);
    reset = 1'b1;
    KEY   = 80'hFFFFFFFFFFFFFFFFFFFF;
    tick(1);
    chk("mid-init reset clears OUT", OUT, '0);
    reset = 1'b0;
    tick(1664);
    chk("mid-init reset new key", OUT, exp_a);

    // Reset in the middle of generation; held several cycles, last KEY wins.
    load(80'h0, 80'h80000000000000000000);
    tick(1152 + 200);
    reset = 1'b1;
    KEY   = 80'h1234;
    tick(1);
    chk("mid-gen reset clears OUT", OUT, '0);
    KEY   = 80'hFFFFFFFFFFFFFFFFFFFF;
    tick(2);
    reset = 1'b0;
    tick(1664);
    chk("mid-gen reset last key wins", OUT, exp_a);

    // Inputs churning outside reset must not disturb the run.
    exp_b = model(80'h0F62B5085BAE0154A7FA, 80'h288FF65DC42B92F960C7);
    load(80'h0F62B5085BAE0154A7FA, 80'h288FF65DC42B92F960C7);
    for (int e = 0; e < 1700; e++) begin
      KEY = {$urandom(), $urandom(), 16'($urandom())};
      IV  = {$urandom(), $urandom(), 16'($urandom())};
      tick(1);
    end
    chk("input isolation", OUT, exp_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
